ard_seq_sender: RTL and testbench
=================================

# ard_seq_sender

Multi-digit successor to the single-digit Arduino sender. On a start pulse it captures up to DEPTH codes and presents them one at a time on a DATA_W-bit parallel bus. Each code is qualified by a strobe, followed by an idle gap. The block sits between the keypad/lock FSM and the Arduino pins. It adds what the single-digit sender lacks: configurable width and depth, an optional ack handshake with timeout, explicit reset, and busy/error reporting.

## Interface
Parameters:
- DATA_W, 3: code/bus width in bits.
- DEPTH, 8: maximum digits per transfer.
- MAX_CODE, 6: largest legal code; larger codes are sent as 0.
- HOLD_CYCLES, 1200000: strobe-high duration per digit when ACK_MODE=0 (1/10 s at 12 MHz).
- GAP_CYCLES, 120000: strobe-low duration between digits, must be ≥1.
- ACK_MODE, 0: 0 = timed hold; 1 = hold until ack, with timeout.
- TIMEOUT_CYCLES, 2400000: ACK_MODE=1 limit for each ack wait.

Ports:
- hwclk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- count  in  $clog2(DEPTH+1)  digits to send; sampled with start.
- codes  in  DEPTH*DATA_W  packed codes; digit i is codes[i*DATA_W +: DATA_W], digit 0 sent first; sampled with start.
- ack  in  1  Arduino acknowledge; used only when ACK_MODE=1.
- data_out  out  DATA_W  current code.
- strobe  out  1  data_out valid.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err_code  out  1  sticky: at least one code > MAX_CODE in this transfer.
- err_timeout  out  1  sticky: transfer aborted on ack timeout.

## Operation
States and transitions:
- IDLE → HOLD when start=1.
  - On that edge: capture codes; capture count, clamped to DEPTH; clear both error flags; set digit index to 0.
  - If the clamped count is 0, go IDLE → DONE instead.
- HOLD: strobe=1; data_out = current code, or 0 if code > MAX_CODE (also sets err_code).
  - ACK_MODE=0: leave after exactly HOLD_CYCLES cycles.
  - ACK_MODE=1: leave on the first cycle ack is sampled high.
  - ACK_MODE=1: if TIMEOUT_CYCLES pass without ack, set err_timeout and go to DONE.
- GAP: strobe=0, data_out=0.
  - ACK_MODE=0: lasts exactly GAP_CYCLES cycles.
  - ACK_MODE=1: lasts until GAP_CYCLES have elapsed AND ack is sampled low. If ack is still high after TIMEOUT_CYCLES, set err_timeout and go to DONE.
  - On exit: if index+1 < count, increment index and return to HOLD; otherwise go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.

Outputs and flags:
- busy=1 in HOLD, GAP and DONE.
- start is ignored while busy=1. A start in the DONE cycle is dropped.
- Error flags hold their value until the next accepted start or rst.
- Captured codes are not affected by changes on codes/count during a transfer.

Reset:
- rst=1 at any edge, including mid-transfer: state IDLE; data_out=0, strobe=0, busy=0, done=0, err_code=0, err_timeout=0.
- rst has priority over start.
- start is accepted on the first edge with rst=0.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- ACK_MODE=0, start accepted at edge 0 with count=N≥1:
  - strobe high in cycles k·(H+G)+1 … k·(H+G)+H, for k=0…N−1.
  - done high in cycle N·(H+G)+1.
  - busy falls in cycle N·(H+G)+2.
- count=0: done in cycle 1, busy high only in cycle 1.
- ACK_MODE=1: ack sampled high at edge t in HOLD → strobe low from cycle t+1.
- Timeout at edge t → done in cycle t+1, strobe=0 from cycle t+1.
- data_out changes only on HOLD entry (new code) and GAP/DONE entry (zero). It is stable for the whole strobe-high window.

## Structure
- Package ard_link_pkg: state enum (IDLE, HOLD, GAP, DONE), DATA_W/MAX_CODE defaults, code-legality function.
- Sub-module ard_phase_timer: loadable down-counter with zero flag.
  - Width $clog2(max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1).
  - Reloaded on every state entry; one instance serves HOLD, GAP and timeout.

## Test plan
- ACK_MODE=0, HOLD=4, GAP=2, count=3, codes {2,5,1}: strobe high cycles 1–4, 7–10, 13–16; data_out 2/5/1 in those windows; done in cycle 19; err flags 0.
- Invalid code: count=2, codes {7,3}, MAX_CODE=6: first window data_out=0 with strobe=1; err_code=1 from cycle 1 until next start.
- count=0 and count=DEPTH+3: done in cycle 1 with no strobe; clamped transfer sends exactly DEPTH digits.
- ACK_MODE=1, TIMEOUT=10: ack after 3 cycles on digit 0; ack never arrives on digit 1 → err_timeout=1, done one cycle after timeout, strobe=0.
- rst asserted mid-HOLD of digit 2: all outputs 0 next cycle; a start in the cycle after rst deasserts begins a fresh transfer at digit 0.
- start held high continuously, plus codes changed mid-transfer: only one transfer per IDLE visit; transmitted codes equal the values captured at start.

Source files
------------

// File: rtl/ard_link_pkg.sv
// Shared definitions for the multi-digit Arduino sender.
//   state_t      : transfer phases (idle, strobe hold, inter-digit gap, done pulse)
//   *_DEF        : default code width and largest legal code
//   code_legal() : true when a code may be sent as-is
//   max_int()    : elaboration-time helper for sizing counters
package ard_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DATA_W_DEF   = 3;
    localparam int MAX_CODE_DEF = 6;

    function automatic logic code_legal(input int unsigned code, input int unsigned max_code);
        return code <= max_code;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ard_phase_timer.sv
// Loadable down-counter shared by every timed phase of the sender.
//   hwclk, rst : clock, synchronous active-high reset
//   load       : reload cnt with load_val (takes priority over counting)
//   load_val   : reload value
//   cnt        : current count, saturates at zero
//   zero       : cnt == 0
module ard_phase_timer #(
    parameter int W = 4
) (
    input  logic         hwclk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge hwclk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ard_seq_sender.sv
// Multi-digit parallel sender towards the Arduino pins.
// A start in idle captures up to DEPTH codes and sends them one by one:
// each code is held with strobe high, then the bus idles for a gap.
//   hwclk, rst   : clock, synchronous active-high reset
//   start        : begin a transfer (ignored while busy)
//   count, codes : digit count and packed codes, sampled with start
//   ack          : Arduino acknowledge (ACK_MODE=1 only)
//   data_out     : current code (0 outside the strobe window)
//   strobe       : data_out valid
//   busy         : transfer in progress (hold, gap, done)
//   done         : one-cycle completion pulse
//   err_code     : sticky, some code exceeded MAX_CODE and was sent as 0
//   err_timeout  : sticky, transfer aborted waiting for ack
module ard_seq_sender
    import ard_link_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int DEPTH          = 8,
    parameter int MAX_CODE       = MAX_CODE_DEF,
    parameter int HOLD_CYCLES    = 1200000,
    parameter int GAP_CYCLES     = 120000,
    parameter int ACK_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 2400000
) (
    input  logic                         hwclk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [DEPTH*DATA_W-1:0]      codes,
    input  logic                         ack,
    output logic [DATA_W-1:0]            data_out,
    output logic                         strobe,
    output logic                         busy,
    output logic                         done,
    output logic                         err_code,
    output logic                         err_timeout
);

    localparam int CW   = $clog2(DEPTH+1);
    localparam int MAXV = max_int(max_int(HOLD_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
    localparam int TW   = $clog2(MAXV+1);

    // In ack mode the hold phase is bounded only by the timeout.
    localparam int HOLD_LD  = (ACK_MODE != 0) ? TIMEOUT_CYCLES - 1 : HOLD_CYCLES - 1;
    // In ack mode the gap timer spans both the minimum gap and the timeout;
    // the elapsed cycle count j is recovered as GAP_SPAN - cnt.
    localparam int GAP_SPAN = (ACK_MODE != 0) ? max_int(TIMEOUT_CYCLES, GAP_CYCLES) : GAP_CYCLES;
    localparam int GAP_LD   = GAP_SPAN - 1;
    localparam int GAP_TH   = GAP_SPAN - GAP_CYCLES;                          // j >= GAP_CYCLES
    localparam int TO_TH    = (ACK_MODE != 0) ? GAP_SPAN - TIMEOUT_CYCLES : 0; // j >= TIMEOUT_CYCLES

    state_t                        state, state_d;
    logic [CW-1:0]                 idx, num, count_clamped;
    logic [DEPTH-1:0][DATA_W-1:0]  codes_q;
    logic [DATA_W-1:0]             entry_code;
    logic                          entry_legal;
    logic                          last_digit, timeout, gap_ok, to_ok;
    logic                          t_load, t_zero;
    logic [TW-1:0]                 t_val, t_cnt;

    ard_phase_timer #(.W(TW)) u_timer (
        .hwclk    (hwclk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .cnt      (t_cnt),
        .zero     (t_zero)
    );

    assign gap_ok = (t_cnt <= TW'(GAP_TH));
    assign to_ok  = (t_cnt <= TW'(TO_TH));

    always_comb begin
        state_d       = state;
        timeout       = 1'b0;
        count_clamped = (count > CW'(DEPTH)) ? CW'(DEPTH) : count;
        last_digit    = ((idx + CW'(1)) >= num);
        case (state)
            ST_IDLE:
                if (start)
                    state_d = (count_clamped == '0) ? ST_DONE : ST_HOLD;
            ST_HOLD:
                if (ACK_MODE != 0) begin
                    // ack wins over a timeout landing on the same cycle
                    if (ack)
                        state_d = ST_GAP;
                    else if (t_zero) begin
                        state_d = ST_DONE;
                        timeout = 1'b1;
                    end
                end else if (t_zero)
                    state_d = ST_GAP;
            ST_GAP:
                if (gap_ok && (ACK_MODE == 0 || !ack))
                    state_d = last_digit ? ST_DONE : ST_HOLD;
                else if (ACK_MODE != 0 && to_ok && ack) begin
                    state_d = ST_DONE;
                    timeout = 1'b1;
                end
            ST_DONE:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Code presented on HOLD entry: digit 0 straight from the inputs on the
    // start edge, otherwise the next captured digit.
    always_comb begin
        entry_code = codes[DATA_W-1:0];
        if (state != ST_IDLE) begin
            entry_code = '0;
            for (int i = 0; i < DEPTH; i++)
                if (CW'(i) == idx + CW'(1))
                    entry_code = codes_q[i];
        end
        entry_legal = code_legal(32'(entry_code), MAX_CODE);
    end

    always_comb begin
        t_load = (state_d != state);
        case (state_d)
            ST_HOLD: t_val = TW'(HOLD_LD);
            ST_GAP:  t_val = TW'(GAP_LD);
            default: t_val = '0;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            num         <= '0;
            codes_q     <= '0;
            data_out    <= '0;
            strobe      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_code    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state  <= state_d;
            strobe <= (state_d == ST_HOLD);
            busy   <= (state_d != ST_IDLE);
            done   <= (state_d == ST_DONE);

            if (state == ST_IDLE && start) begin
                codes_q     <= codes;
                num         <= count_clamped;
                idx         <= '0;
                err_code    <= 1'b0;
                err_timeout <= 1'b0;
            end

            // Placed after the capture clear so an illegal digit 0 still flags.
            if (state_d == ST_HOLD && state != ST_HOLD) begin
                data_out <= entry_legal ? entry_code : '0;
                if (!entry_legal)
                    err_code <= 1'b1;
                if (state == ST_GAP)
                    idx <= idx + CW'(1);
            end else if (state_d != ST_HOLD) begin
                data_out <= '0;
            end

            if (timeout)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ard_seq_sender.sv
// Bench for ard_seq_sender: one timed-mode and one ack-mode instance share
// all inputs. A procedural per-transfer model predicts every output each
// cycle; directed sections add literal expectations for the key scenarios.
module tb_ard_seq_sender;

    localparam int DW    = 3;
    localparam int DEPTH = 4;
    localparam int MAXC  = 6;
    localparam int H     = 4;
    localparam int G     = 2;
    localparam int T     = 10;
    localparam int CW    = $clog2(DEPTH+1);

    logic                  hwclk = 1'b0;
    logic                  rst, start, ack;
    logic [CW-1:0]         count;
    logic [DEPTH*DW-1:0]   codes;
    logic [DW-1:0]         data_out [2];
    logic                  strobe [2], busy [2], done [2], err_code [2], err_timeout [2];

    logic [DW-1:0]         exp_data [2];
    logic                  exp_strobe [2], exp_busy [2], exp_done [2], exp_ec [2], exp_et [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 hwclk = ~hwclk;

    ard_seq_sender #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_CODE(MAXC), .HOLD_CYCLES(H),
                     .GAP_CYCLES(G), .ACK_MODE(0), .TIMEOUT_CYCLES(T)) dut0 (
        .hwclk(hwclk), .rst(rst), .start(start), .count(count), .codes(codes), .ack(ack),
        .data_out(data_out[0]), .strobe(strobe[0]), .busy(busy[0]), .done(done[0]),
        .err_code(err_code[0]), .err_timeout(err_timeout[0]));

    ard_seq_sender #(.DATA_W(DW), .DEPTH(DEPTH), .MAX_CODE(MAXC), .HOLD_CYCLES(H),
                     .GAP_CYCLES(G), .ACK_MODE(1), .TIMEOUT_CYCLES(T)) dut1 (
        .hwclk(hwclk), .rst(rst), .start(start), .count(count), .codes(codes), .ack(ack),
        .data_out(data_out[1]), .strobe(strobe[1]), .busy(busy[1]), .done(done[1]),
        .err_code(err_code[1]), .err_timeout(err_timeout[1]));

    // ---------------- behavioural model ----------------
    task automatic zero_exp(input int m);
        exp_data[m] = '0; exp_strobe[m] = 1'b0; exp_busy[m] = 1'b0;
        exp_done[m] = 1'b0; exp_ec[m] = 1'b0; exp_et[m] = 1'b0;
    endtask

    task automatic step(input int m, output bit aborted);
        @(posedge hwclk);
        aborted = rst;
        if (rst) zero_exp(m);
    endtask

    task automatic finish_xfer(input int m);
        bit ab;
        exp_done[m] = 1'b1; exp_strobe[m] = 1'b0; exp_data[m] = '0; exp_busy[m] = 1'b1;
        step(m, ab);
        if (!ab) begin exp_done[m] = 1'b0; exp_busy[m] = 1'b0; end
    endtask

    task automatic transfer(input int m);
        logic [DW-1:0] cap [DEPTH];
        int n, j;
        bit ab;
        for (int i = 0; i < DEPTH; i++) cap[i] = codes[i*DW +: DW];
        n = (int'(count) > DEPTH) ? DEPTH : int'(count);
        exp_ec[m] = 1'b0; exp_et[m] = 1'b0; exp_busy[m] = 1'b1;
        for (int k = 0; k < n; k++) begin
            exp_strobe[m] = 1'b1;
            if (int'(cap[k]) > MAXC) begin exp_data[m] = '0; exp_ec[m] = 1'b1; end
            else exp_data[m] = cap[k];
            j = 0;
            forever begin
                step(m, ab); if (ab) return; j++;
                if (m == 0) begin
                    if (j == H) break;
                end else begin
                    if (ack) break;
                    if (j == T) begin exp_et[m] = 1'b1; finish_xfer(m); return; end
                end
            end
            exp_strobe[m] = 1'b0; exp_data[m] = '0;
            j = 0;
            forever begin
                step(m, ab); if (ab) return; j++;
                if (j >= G && (m == 0 || !ack)) break;
                if (m == 1 && j >= T && ack) begin exp_et[m] = 1'b1; finish_xfer(m); return; end
            end
        end
        finish_xfer(m);
    endtask

    task automatic model_run(input int m);
        forever begin
            @(posedge hwclk);
            if (rst) zero_exp(m);
            else if (start) transfer(m);
        end
    endtask

    initial model_run(0);
    initial model_run(1);

    // ---------------- checking ----------------
    task automatic cmp_model(input int m);
        checks++;
        if (data_out[m] !== exp_data[m] || strobe[m] !== exp_strobe[m] || busy[m] !== exp_busy[m] ||
            done[m] !== exp_done[m] || err_code[m] !== exp_ec[m] || err_timeout[m] !== exp_et[m]) begin
            errors++;
            $display("FAIL model_dut%0d t=%0t: got d=%0d s=%0b b=%0b dn=%0b ec=%0b et=%0b expected d=%0d s=%0b b=%0b dn=%0b ec=%0b et=%0b",
                     m, $time, data_out[m], strobe[m], busy[m], done[m], err_code[m], err_timeout[m],
                     exp_data[m], exp_strobe[m], exp_busy[m], exp_done[m], exp_ec[m], exp_et[m]);
        end
    endtask

    always @(negedge hwclk) if (chk_en) begin cmp_model(0); cmp_model(1); end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge hwclk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0; start = 1'b0; ack = 1'b0;
        while ((busy[0] || busy[1]) && n < 200) begin tick(); n++; end
        if (busy[0] || busy[1]) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy=%0b/%0b after %0d cycles, required 0", busy[0], busy[1], n);
        end
    endtask

    function automatic logic [DEPTH*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    // Leaves the bench inside cycle 1 of the transfer.
    task automatic launch(input int n, input logic [DEPTH*DW-1:0] c);
        count = CW'(n); codes = c; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rises, done_c, pidx;
        bit prev;
        int p_tab [4];
        p_tab = '{25, 60, 3, 90};
        rst = 1'b1; start = 1'b0; ack = 1'b0; count = '0; codes = '0;
        tick(); tick();
        chk_en = 1'b1;
        @(negedge hwclk);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("reset_strobe%0d", m), int'(strobe[m]), 0);
            chk($sformatf("reset_busy%0d", m),   int'(busy[m]), 0);
            chk($sformatf("reset_data%0d", m),   int'(data_out[m]), 0);
        end
        tick();
        rst = 1'b0;
        tick();

        // Timed mode, three digits.
        wait_idle();
        launch(3, pack4(2, 5, 1, 0));
        for (int c = 1; c <= 20; c++) begin
            @(negedge hwclk);
            chk($sformatf("t1_strobe_c%0d", c), int'(strobe[0]),
                int'((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16)));
            chk($sformatf("t1_data_c%0d", c), int'(data_out[0]),
                (c <= 4) ? 2 : (c >= 7 && c <= 10) ? 5 : (c >= 13 && c <= 16) ? 1 : 0);
            chk($sformatf("t1_done_c%0d", c), int'(done[0]), int'(c == 19));
            chk($sformatf("t1_busy_c%0d", c), int'(busy[0]), int'(c <= 19));
            chk($sformatf("t1_err_c%0d", c), int'(err_code[0]), 0);
            tick();
        end

        // Illegal code sent as zero with sticky flag.
        wait_idle();
        launch(2, pack4(7, 3, 0, 0));
        for (int c = 1; c <= 14; c++) begin
            @(negedge hwclk);
            chk($sformatf("t2_err_code_c%0d", c), int'(err_code[0]), 1);
            if (c == 1) begin
                chk("t2_strobe_c1", int'(strobe[0]), 1);
                chk("t2_data_c1", int'(data_out[0]), 0);
            end
            if (c == 7) chk("t2_data_c7", int'(data_out[0]), 3);
            if (c == 13) chk("t2_done_c13", int'(done[0]), 1);
            tick();
        end
        wait_idle();
        @(negedge hwclk);
        chk("t2_err_sticky_idle", int'(err_code[0]), 1);
        tick();
        launch(1, pack4(1, 0, 0, 0));
        @(negedge hwclk);
        chk("t2_err_cleared", int'(err_code[0]), 0);
        chk("t2_next_data", int'(data_out[0]), 1);

        // Zero count and clamped count.
        wait_idle();
        launch(0, pack4(3, 3, 3, 3));
        @(negedge hwclk);
        chk("t3_zero_done_c1", int'(done[0]), 1);
        chk("t3_zero_strobe_c1", int'(strobe[0]), 0);
        chk("t3_zero_busy_c1", int'(busy[0]), 1);
        tick();
        @(negedge hwclk);
        chk("t3_zero_busy_c2", int'(busy[0]), 0);
        wait_idle();
        launch(DEPTH + 3, pack4(1, 2, 3, 4));
        rises = 0; done_c = 0; prev = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge hwclk);
            if (strobe[0] && !prev) rises++;
            prev = strobe[0];
            if (done[0] && done_c == 0) done_c = c;
            tick();
        end
        chk("t3_clamp_digits", rises, DEPTH);
        chk("t3_clamp_done_cycle", done_c, 25);

        // Ack mode: ack on digit 0 after 3 cycles, none on digit 1.
        wait_idle();
        launch(3, pack4(1, 2, 3, 0));
        for (int c = 1; c <= 17; c++) begin
            ack = (c == 3);
            @(negedge hwclk);
            chk($sformatf("t4_strobe_c%0d", c), int'(strobe[1]), int'(c <= 3 || (c >= 6 && c <= 15)));
            chk($sformatf("t4_data_c%0d", c), int'(data_out[1]),
                (c <= 3) ? 1 : (c >= 6 && c <= 15) ? 2 : 0);
            chk($sformatf("t4_done_c%0d", c), int'(done[1]), int'(c == 16));
            chk($sformatf("t4_err_to_c%0d", c), int'(err_timeout[1]), int'(c >= 16));
            if (c == 17) chk("t4_busy_c17", int'(busy[1]), 0);
            tick();
        end
        ack = 1'b0;

        // Reset during digit 2 hold, then immediate restart.
        wait_idle();
        launch(3, pack4(4, 5, 6, 0));
        repeat (13) tick();
        rst = 1'b1;
        @(negedge hwclk);
        chk("t5_pre_rst_strobe", int'(strobe[0]), 1);
        chk("t5_pre_rst_data", int'(data_out[0]), 6);
        tick();
        rst = 1'b0; count = CW'(3); codes = pack4(2, 3, 4, 0); start = 1'b1;
        @(negedge hwclk);
        chk("t5_rst_strobe", int'(strobe[0]), 0);
        chk("t5_rst_busy", int'(busy[0]), 0);
        chk("t5_rst_data", int'(data_out[0]), 0);
        chk("t5_rst_done", int'(done[0]), 0);
        tick();
        start = 1'b0;
        @(negedge hwclk);
        chk("t5_restart_strobe", int'(strobe[0]), 1);
        chk("t5_restart_data", int'(data_out[0]), 2);
        chk("t5_restart_busy", int'(busy[0]), 1);

        // start held high, codes changed mid-transfer.
        wait_idle();
        count = CW'(2); codes = pack4(3, 4, 0, 0); start = 1'b1;
        tick();
        for (int c = 1; c <= 15; c++) begin
            if (c == 5) codes = pack4(6, 6, 6, 6);
            @(negedge hwclk);
            if (c == 8) begin
                chk("t6_captured_data", int'(data_out[0]), 4);
                chk("t6_captured_strobe", int'(strobe[0]), 1);
            end
            if (c == 13) chk("t6_done", int'(done[0]), 1);
            if (c == 14) begin
                chk("t6_idle_busy", int'(busy[0]), 0);
                chk("t6_idle_strobe", int'(strobe[0]), 0);
            end
            if (c == 15) begin
                chk("t6_second_strobe", int'(strobe[0]), 1);
                chk("t6_second_data", int'(data_out[0]), 6);
            end
            tick();
        end
        start = 1'b0;

        // Randomised traffic against the model.
        wait_idle();
        for (int it = 0; it < 2000; it++) begin
            pidx  = it / 500;
            start = ($urandom_range(0, 5) == 0);
            count = CW'($urandom_range(0, 7));
            codes = (DEPTH*DW)'($urandom);
            ack   = ($urandom_range(0, 99) < p_tab[pidx]);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        wait_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
